// File: rtl/reservoir_step_ctrl.sv
// Sequencer for the LIF reservoir: accepts samples, steps the reservoir TICKS times per sample,
// counts spikes per neuron and streams the counts to the readout. Option: RESCTRL_SKIP_ZERO_EN.
module reservoir_step_ctrl #(
   parameter int N       = 64,
   parameter int TICKS   = 8,
   parameter int WASHOUT = 4,
   parameter int COUNT_W = 4,
   parameter int IDX_W   = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               washout_done,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [15:0]        s_data,
   output logic               res_clear,
   output logic               res_step,
   output logic [15:0]        res_input,
   input  logic [N-1:0]       res_spikes,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [IDX_W-1:0]   m_index,
   output logic [COUNT_W-1:0] m_count,
   output logic               m_last
);

   localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int SCNT_W = (WASHOUT > 0) ? $clog2(WASHOUT + 1) : 1;
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT,
      S_RUN,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [SCNT_W-1:0]    scnt_q, scnt_d;
   logic                 wo_done_q, wo_done_d;
   logic [15:0]          res_input_q, res_input_d;
   logic                 step_q, step_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [COUNT_W-1:0]   cnt_q [N];
   logic [COUNT_W-1:0]   cnt_d [N];

   logic                 accept;
   logic [IDX_W-1:0]     first_idx;
   logic [IDX_W-1:0]     next_idx;
   logic                 drain_last;

   assign accept = (state_q == S_WAIT) && s_valid;
   assign step_d = (state_q == S_RUN);

   // The spike vector is registered in the reservoir, so it lags res_step by one cycle.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         cnt_d[k] = cnt_q[k];
         if (accept) begin
            cnt_d[k] = '0;
         end else if (step_q && res_spikes[k] && (cnt_q[k] != CNT_MAX)) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
         end
      end
   end

`ifdef RESCTRL_SKIP_ZERO_EN
   logic [N-1:0] nz_cur, nz_next;
   logic [IDX_W:0] first_hit, next_hit;

   // Returns {found, index} of the lowest set bit at or above lo.
   function automatic logic [IDX_W:0] first_set(input logic [N-1:0] v, input int lo);
      logic [IDX_W:0] r;
      r = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if ((k >= lo) && v[k]) r = {1'b1, IDX_W'(k)};
      end
      return r;
   endfunction

   always_comb begin
      for (int k = 0; k < N; k++) begin
         nz_cur[k]  = (cnt_q[k] != '0);
         nz_next[k] = (cnt_d[k] != '0);
      end
   end

   // The first beat is chosen on the CAPTURE edge, which also carries the last count update.
   assign first_hit  = first_set(nz_next, 0);
   assign next_hit   = first_set(nz_cur, int'(idx_q) + 1);
   assign first_idx  = first_hit[IDX_W] ? first_hit[IDX_W-1:0] : IDX_W'(N - 1);
   assign next_idx   = next_hit[IDX_W-1:0];
   assign drain_last = !next_hit[IDX_W];
`else
   assign first_idx  = '0;
   assign next_idx   = idx_q + 1'b1;
   assign drain_last = (idx_q == IDX_W'(N - 1));
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      tick_d      = tick_q;
      scnt_d      = scnt_q;
      wo_done_d   = wo_done_q;
      res_input_d = res_input_q;
      idx_d       = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            scnt_d    = '0;
            wo_done_d = (WASHOUT == 0);
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (s_valid) begin
               res_input_d = s_data;
               tick_d      = '0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (tick_q == TICK_W'(TICKS - 1)) begin
               state_d = S_CAPTURE;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            if (int'(scnt_q) < WASHOUT) begin
               scnt_d    = scnt_q + 1'b1;
               wo_done_d = ((int'(scnt_q) + 1) == WASHOUT);
               state_d   = S_WAIT;
            end else begin
               idx_d   = first_idx;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (m_ready) begin
               if (drain_last) begin
                  state_d = S_WAIT;
               end else begin
                  idx_d = next_idx;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         scnt_q      <= '0;
         wo_done_q   <= 1'b0;
         res_input_q <= '0;
         step_q      <= 1'b0;
         idx_q       <= '0;
         // NOTE: the count array is plain flops, not a RAM, so it can and does take the reset.
         for (int k = 0; k < N; k++) cnt_q[k] <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q     <= state_d;
         tick_q      <= tick_d;
         scnt_q      <= scnt_d;
         wo_done_q   <= wo_done_d;
         res_input_q <= res_input_d;
         step_q      <= step_d;
         idx_q       <= idx_d;
         for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign washout_done = wo_done_q;
   assign s_ready      = (state_q == S_WAIT);
   assign res_clear    = (state_q == S_CLEAR);
   assign res_step     = (state_q == S_RUN);
   assign res_input    = res_input_q;
   assign m_valid      = (state_q == S_DRAIN);
   assign m_index      = m_valid ? idx_q : '0;
   assign m_count      = m_valid ? cnt_q[idx_q] : '0;
   assign m_last       = m_valid && drain_last;

endmodule

// File: tb/tb_reservoir_step_ctrl.sv
// Directed bench for reservoir_step_ctrl: washout, step window, counting, saturation (COUNT_W=3
// twin), backpressure, abort, restart and reset. Follows RESCTRL_SKIP_ZERO_EN when defined.
module tb_reservoir_step_ctrl;

   localparam int N       = 64;
   localparam int TICKS   = 8;
   localparam int WASHOUT = 4;

   logic          clk = 1'b0;
   logic          reset_n, start, abort, s_valid, m_ready;
   logic [15:0]   s_data;
   logic [N-1:0]  res_spikes;

   logic          busy, washout_done, s_ready, res_clear, res_step, m_valid, m_last;
   logic [15:0]   res_input;
   logic [5:0]    m_index;
   logic [3:0]    m_count;

   logic          busy_s, washout_done_s, s_ready_s, res_clear_s, res_step_s, m_valid_s, m_last_s;
   logic [15:0]   res_input_s;
   logic [5:0]    m_index_s;
   logic [2:0]    m_count_s;

   int n_checks = 0;
   int n_errors = 0;
   int wo_cnt;
   int exp_idx [N];
   int exp_cnt [N];
   int nb;

   reservoir_step_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy),
      .washout_done(washout_done), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .res_clear(res_clear), .res_step(res_step), .res_input(res_input), .res_spikes(res_spikes),
      .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_count(m_count), .m_last(m_last)
   );

   reservoir_step_ctrl #(.COUNT_W(3)) dut_sat (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy_s),
      .washout_done(washout_done_s), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
      .res_clear(res_clear_s), .res_step(res_step_s), .res_input(res_input_s),
      .res_spikes(res_spikes), .m_valid(m_valid_s), .m_ready(m_ready), .m_index(m_index_s),
      .m_count(m_count_s), .m_last(m_last_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Spike vector held constant over the window: a spiking neuron collects TICKS spikes.
   task automatic build_expect(input logic [N-1:0] sp);
      nb = 0;
      for (int k = 0; k < N; k++) begin
`ifdef RESCTRL_SKIP_ZERO_EN
         if (sp[k]) begin
            exp_idx[nb] = k;
            exp_cnt[nb] = TICKS;
            nb++;
         end
`else
         exp_idx[nb] = k;
         exp_cnt[nb] = sp[k] ? TICKS : 0;
         nb++;
`endif
      end
      if (nb == 0) begin
         exp_idx[0] = N - 1;
         exp_cnt[0] = 0;
         nb = 1;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("clear_pulse", res_clear, 1'b1);
      check("busy_clear", busy, 1'b1);
      @(negedge clk);
      check("clear_one_cycle", res_clear, 1'b0);
      check("washout_restart", washout_done, 1'b0);
      check("s_ready_wait", s_ready, 1'b1);
      wo_cnt = 0;
   endtask

   task automatic run_sample(input logic [15:0] data, input logic [N-1:0] sp,
                             input int stall_idx, input int abort_idx);
      bit exp_out;
      int waited, steps, j, stall_left;
      exp_out    = (wo_cnt >= WASHOUT);
      res_spikes = sp;
      s_data     = data;
      s_valid    = 1'b1;
      waited     = 0;
      while (!s_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("s_ready_timeout", s_ready, 1'b1);
      if (!s_ready) begin
         s_valid = 1'b0;
         return;
      end
      @(negedge clk);
      s_valid = 1'b0;
      steps = 0;
      for (int n = 1; n <= TICKS + 1; n++) begin
         if (res_step) steps++;
         check("res_input_hold", res_input, data);
         check("s_ready_busy", s_ready, 1'b0);
         if (n == TICKS + 1) check("step_off_capture", res_step, 1'b0);
         @(negedge clk);
      end
      check("step_count", steps, TICKS);
      check("first_m_valid", m_valid, exp_out);
      if (!exp_out) begin
         wo_cnt++;
         check("washout_done", washout_done, wo_cnt >= WASHOUT);
         check("s_ready_back", s_ready, 1'b1);
         return;
      end
      build_expect(sp);
      j = 0;
      stall_left = 5;
      for (int cyc = 0; cyc < 400 && m_valid; cyc++) begin
         if (j >= nb) begin
            check("beat_overrun", j, nb);
            break;
         end
         check("m_index", m_index, exp_idx[j]);
         check("m_count", m_count, exp_cnt[j]);
         check("m_count_sat", m_count_s, (exp_cnt[j] > 7) ? 7 : exp_cnt[j]);
         check("m_last", m_last, j == nb - 1);
         check("s_ready_drain", s_ready, 1'b0);
         if (int'(m_index) == abort_idx) begin
            abort   = 1'b1;
            m_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            check("abort_m_valid", m_valid, 1'b0);
            check("abort_m_last", m_last, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_s_ready", s_ready, 1'b0);
            return;
         end
         if (int'(m_index) == stall_idx && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end else begin
            m_ready = 1'b1;
            j++;
         end
         @(negedge clk);
      end
      m_ready = 1'b0;
      check("beat_total", j, nb);
      check("drain_done", m_valid, 1'b0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      s_valid    = 1'b0;
      m_ready    = 1'b0;
      s_data     = '0;
      res_spikes = '0;
      wo_cnt     = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_res_input", res_input, 16'h0000);
      check("rst_res_step", res_step, 1'b0);
      check("rst_res_clear", res_clear, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_washout", washout_done, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_s_ready", s_ready, 1'b0);

      do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_ignored_clear", res_clear, 1'b0);
      check("start_ignored_ready", s_ready, 1'b1);

      // Four washout samples, then a full drain with a 5-cycle stall at index 10.
      for (int s = 0; s < WASHOUT; s++) begin
         run_sample(16'h0800, 64'h8000_0000_0000_0408, -1, -1);
      end
      run_sample(16'h0800, 64'h8000_0000_0000_0408, 10, -1);
      run_sample(16'h1234, 64'h0000_0100_0000_0004, -1, -1);
      run_sample(16'hF800, 64'h0, -1, -1);
      run_sample(16'hA5A5, '1, -1, 20);
      check("res_input_after_abort", res_input, 16'hA5A5);

      do_start();
      run_sample(16'h0100, 64'h1, -1, -1);

      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_wait_idle", busy, 1'b0);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_beats_start", busy, 1'b0);
      check("abort_beats_start_clr", res_clear, 1'b0);

      // Reset in the middle of the step window.
      do_start();
      s_data  = 16'h0300;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      check("mid_run_step", res_step, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_run_step", res_step, 1'b0);
      check("rst_run_busy", busy, 1'b0);
      check("rst_run_input", res_input, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_run_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reservoir_step_ctrl.md
Name: reservoir_step_ctrl

Overview:
Sequencer for the 64-neuron LIF reservoir.
- Accepts Q4.12 input samples over a valid/ready stream and holds each sample on the reservoir input.
- Clock-enables the reservoir for a fixed number of ticks per sample and counts spikes per neuron over that window.
- Streams the per-neuron counts to the readout serially, after an initial washout period.
- Sits between the sample source and the reservoir core, and between the reservoir and the readout layer.

Parameters:
- N, 64, number of reservoir neurons.
- TICKS, 8, reservoir update cycles per input sample (>=1).
- WASHOUT, 4, initial samples after start whose counts are discarded (>=0).
- COUNT_W, 4, spike-count width per neuron.
- IDX_W, 6, neuron index width; equals $clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a run from IDLE.
- abort  in  1  return to IDLE; highest priority.
- busy  out  1  high whenever state != IDLE.
- washout_done  out  1  high once WASHOUT samples have been consumed in this run.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_data  in  16  signed Q4.12 sample.
- res_clear  out  1  one-cycle reservoir state clear.
- res_step  out  1  reservoir clock-enable (one update per cycle high).
- res_input  out  16  signed sample driven to the reservoir.
- res_spikes  in  N  registered spike vector from the reservoir.
- m_valid  out  1  readout beat valid.
- m_ready  in  1  readout accepts beat.
- m_index  out  IDX_W  neuron index of the current beat.
- m_count  out  COUNT_W  spike count of neuron m_index.
- m_last  out  1  marks the final beat of a sample's readout.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE.
  - All outputs 0, including res_input = 0.
  - Counts, tick counter and sample counter cleared.
- States: IDLE, CLEAR, WAIT, RUN, CAPTURE, DRAIN. Outputs are Moore, decoded from registered state and counters.
- IDLE:
  - s_ready = 0.
  - start -> CLEAR.
- CLEAR (1 cycle):
  - res_clear = 1.
  - Sample counter set to 0; washout_done = (WASHOUT == 0).
  - Next state WAIT.
- WAIT:
  - s_ready = 1.
  - On s_valid & s_ready: latch s_data into res_input, zero all N counts, tick = 0, go to RUN.
  - res_input holds its value until the next accepted sample or reset. It is not cleared by abort.
- RUN:
  - res_step = 1 for exactly TICKS consecutive cycles, then CAPTURE.
- CAPTURE (1 cycle):
  - res_step = 0.
  - Exists to collect the spikes produced by the final step.
- Spike counting:
  - On every cycle where the registered copy of res_step is 1, count[k] += res_spikes[k] for each k.
  - This covers the last TICKS-1 RUN cycles plus CAPTURE, i.e. exactly TICKS samples of the spike vector.
  - Each count saturates at 2^COUNT_W-1.
- After CAPTURE:
  - If sample counter < WASHOUT: increment it, go to WAIT, emit no output. washout_done rises when the counter reaches WASHOUT.
  - Otherwise go to DRAIN.
- DRAIN:
  - m_valid = 1, m_index starts at 0, m_count = count[m_index].
  - m_index advances only on m_valid & m_ready. m_valid, m_index and m_count stay stable while m_ready = 0.
  - m_last = 1 when m_index = N-1.
  - Handshake on the last beat -> WAIT.
  - s_ready = 0 throughout DRAIN; no sample overlaps a drain.
- Latency: first m_valid is asserted TICKS+1 cycles after the sample-accept edge (9 with defaults).
- Abort:
  - From any state, the next state is IDLE and all strobes (res_step, m_valid, s_ready) are 0 the next cycle.
  - A partial drain is dropped with no m_last.
  - If abort and start arrive in the same cycle, abort wins.
- start outside IDLE is ignored.
- Reset asserted mid-RUN or mid-DRAIN: immediate return to reset values; no partial beat completes.

Optional Feature:
- Macro: RESCTRL_SKIP_ZERO_EN.
- Defined:
  - DRAIN emits only neurons with count != 0, in ascending index order.
  - m_last marks the highest-index nonzero neuron.
  - If all counts are 0, exactly one beat is emitted: index N-1, count 0, m_last = 1.
  - Drain length = max(1, number of nonzero neurons).
- Undefined: all N neurons are emitted, as in Behaviour.

Test Plan:
- Washout: reset, start, WASHOUT=4, push 5 samples of 0x0800 with m_ready = 1 -> no m_valid for samples 1-4; washout_done rises after sample 4; exactly 64 beats for sample 5, m_last only at index 63.
- Step window: after accepting a sample, res_step is high for exactly 8 consecutive cycles; first m_valid at accept edge + 9; res_input = 0x0800 throughout.
- Counting/saturation: model neuron 3 spiking every cycle and neuron 7 never -> count[3] = 8, count[7] = 0; with COUNT_W=3 and neuron 3 spiking 8 times -> count[3] = 7.
- Backpressure: hold m_ready = 0 for 5 cycles at index 10 -> m_index/m_count stable; s_ready = 0 throughout the drain.
- Abort mid-DRAIN at index 20 -> m_valid = 0 next cycle, busy = 0, no m_last; a new start produces one res_clear pulse and washout restarts from 0.
- RESCTRL_SKIP_ZERO_EN: only neurons 2 and 40 spike -> 2 beats (2, 40), m_last on index 40; no spikes -> one beat (63, 0, last).
